mux_lane_scheduler: RTL and testbench
=====================================

// Module: mux_lane_scheduler
// PURPOSE
//   Burst round-robin scheduler for the 4-lane byte mux path. Grants one of four
//   valid/ready input lanes at a time and drives the mux selector.
//   Forwards granted-lane bytes through a registered valid/ready output stage.
//   Sits between the lane sources and the downstream serializer, all in the clk_4f domain.
// PARAMETERS
//   DATA_W     8  lane/output data width
//   BURST_LEN  4  max beats accepted per grant, >=1
// PORTS
//   clk_4f      in   1         sole clock, all logic on rising edge
//   reset       in   1         synchronous, active-high; one clock, reset synchronous active-high
//   valid_in    in   4         per-lane valid; bit i = lane i
//   data_in0..3 in   DATA_W    lane data; must hold while valid_in[i] && !ready_out[i]
//   ready_out   out  4         per-lane ready; only the granted lane's bit can be 1
//   selector    out  2         mux select = granted lane index
//   valid_out   out  1         output beat valid (registered)
//   data_out    out  DATA_W    output beat data (registered)
//   ready_in    in   1         downstream ready
// BEHAVIOUR
//   Reset values: valid_out=0, data_out=0, ready_out=0, selector=0, state=IDLE,
//     beat_cnt=0, last_grant=3 (lane 0 wins first).
//   FSM has two states, IDLE and BURST.
//   - IDLE, valid_in!=0: pick the first valid lane after last_grant, wrapping 3->0.
//     Set selector and last_grant to it, clear beat_cnt, go to BURST.
//     The arbitration cycle is a bubble: no accept in IDLE.
//   - IDLE, valid_in==0: stay in IDLE; selector holds its previous value.
//   - BURST: ready_out[selector] = !valid_out || ready_in (combinational).
//     An accept is ready_out[g] && valid_in[g]. It loads data_out, sets valid_out=1
//     and increments beat_cnt. Latency from accept to valid_out is 1 cycle.
//   - BURST -> IDLE on an accept with beat_cnt==BURST_LEN-1.
//   - BURST -> IDLE also when ready_out[g]=1 && valid_in[g]=0 (early end, no beat).
//   - valid_out clears on a valid_out && ready_in cycle with no new accept.
//   - Simultaneous drain and accept in one cycle passes the new beat, no bubble.
//   - Backpressure (ready_in=0): data_out/valid_out hold; no beat lost or duplicated.
//   - The output register may still hold a beat after the FSM returns to IDLE;
//     it drains independently of the FSM.
//   - Non-granted lanes are ignored; selector is stable for the whole burst.
//   - beat_cnt width = $clog2(BURST_LEN+1), so BURST_LEN=1 is legal.
//   - Reset mid-burst: all state returns to reset values on the next edge;
//     any in-flight output beat is dropped.
//   Throughput: BURST_LEN beats per BURST_LEN+1 cycles with all lanes valid and ready_in=1.
// CONFIGURATION
//   STRICT_PRIO_EN defined: in IDLE, lane 0 wins whenever valid_in[0]=1.
//     Otherwise round-robin runs over lanes 1..3 only; lane-0 grants leave
//     the lane 1..3 RR pointer unchanged. Burst rules are unchanged.
//   STRICT_PRIO_EN undefined: plain 4-lane round-robin as above.
// STRUCTURE
//   mux_sched_pkg holds:
//     NUM_LANES=4, SEL_W=2, state enum {IDLE, BURST}, function next_rr(req, last).
//   Sub-module rr_arbiter4 is combinational: (req[3:0], last[1:0]) -> grant[1:0],
//     any. The macro selects its strict-priority variant. FSM and output register
//     stay in the top.
// TESTING
//   1 reset=1 with valid_in=4'hF for 5 cycles -> valid_out=0, ready_out=0, selector=0.
//   2 BURST_LEN=2, all lanes valid, data 0xEE/0x01/0xFF/0xFD held, ready_in=1
//     -> data_out EE,EE,01,01,FF,FF,FD,FD,EE.., one bubble between bursts.
//   3 ready_in=0 for 3 cycles mid-burst -> data_out and valid_out frozen,
//     ready_out=0; resume gives the exact beat sequence.
//   4 only lane 2 valid for 1 beat, then valid low -> burst ends early, IDLE;
//     revalidate -> lane 2 granted again, selector=2.
//   5 reset pulsed mid-burst on lane 1 -> next cycle valid_out=0, IDLE;
//     first grant after reset is lane 0.
//   6 lanes 0 and 3 valid continuously -> grants alternate 0,3 without the macro;
//     only lane 0 is granted with STRICT_PRIO_EN defined.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared lane-mux scheduler types and the round-robin pick helper.
// Pure declarations; no timing or flow-control behaviour of its own.
package mux_sched_pkg;

    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Closest requesting lane after 'last', wrapping 3->0; returns 'last' if none request.
    function automatic logic [SEL_W-1:0] next_rr(input logic [NUM_LANES-1:0] req,
                                                 input logic [SEL_W-1:0]     last);
        logic [SEL_W-1:0] idx;
        next_rr = last;
        for (int k = NUM_LANES; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) begin
                next_rr = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-lane round-robin pick, zero latency, no flow control.
// STRICT_PRIO_EN: lane 0 always wins when requesting; lanes 1..3 rotate.
module rr_arbiter4
    import mux_sched_pkg::*;
(
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [SEL_W-1:0]     last_i,
    output logic [SEL_W-1:0]     grant_o,
    output logic                 any_o
);

    assign any_o = |req_i;

`ifdef STRICT_PRIO_EN
    always_comb begin
        if (req_i[0]) begin
            grant_o = '0;
        end else begin
            grant_o = next_rr({req_i[NUM_LANES-1:1], 1'b0}, last_i);
        end
    end
`else
    assign grant_o = next_rr(req_i, last_i);
`endif

endmodule

// File: rtl/mux_lane_scheduler.sv
// Burst round-robin scheduler for the 4-lane byte mux; 1-cycle accept-to-output latency,
// one arbitration bubble per burst. Lane ready follows !valid_out || ready_in. STRICT_PRIO_EN selects strict lane-0 priority.
module mux_lane_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
)
(
    input  logic                 clk_4f,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] valid_in,
    input  logic [DATA_W-1:0]    data_in0,
    input  logic [DATA_W-1:0]    data_in1,
    input  logic [DATA_W-1:0]    data_in2,
    input  logic [DATA_W-1:0]    data_in3,
    output logic [NUM_LANES-1:0] ready_out,
    output logic [SEL_W-1:0]     selector,
    output logic                 valid_out,
    output logic [DATA_W-1:0]    data_out,
    input  logic                 ready_in
);

    localparam int               CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic                vld_q, vld_d;
    logic [DATA_W-1:0]   dat_q, dat_d;

    logic [SEL_W-1:0]    arb_grant;
    logic                arb_any;
    logic                out_rdy;
    logic                lane_vld;
    logic [DATA_W-1:0]   lane_dat;
    logic                in_burst;
    logic                accept;

    rr_arbiter4 u_arb (
        .req_i   (valid_in),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    always_comb begin
        lane_dat = data_in0;
        case (sel_q)
            2'd1:    lane_dat = data_in1;
            2'd2:    lane_dat = data_in2;
            2'd3:    lane_dat = data_in3;
            default: lane_dat = data_in0;
        endcase
    end

    assign in_burst = (state_q == BURST);
    assign out_rdy  = !vld_q || ready_in;
    assign lane_vld = valid_in[sel_q];
    assign accept   = in_burst && out_rdy && lane_vld;

    always_comb begin
        ready_out = '0;
        if (in_burst) begin
            ready_out[sel_q] = out_rdy;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        beat_d  = beat_q;
        if (!in_burst) begin
            if (arb_any) begin
                sel_d   = arb_grant;
                beat_d  = '0;
                state_d = BURST;
`ifdef STRICT_PRIO_EN
                // Lane-0 wins bypass the rotation so lanes 1..3 keep their turn order.
                if (arb_grant != '0) begin
                    last_d = arb_grant;
                end
`else
                last_d = arb_grant;
`endif
            end
        end else if (out_rdy) begin
            if (lane_vld) begin
                beat_d = beat_q + 1'b1;
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Output stage drains on its own, independent of the FSM.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (accept) begin
            vld_d = 1'b1;
            dat_d = lane_dat;
        end else if (vld_q && ready_in) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(NUM_LANES - 1);
            beat_q  <= '0;
            vld_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
        end
    end

    assign selector  = sel_q;
    assign valid_out = vld_q;
    assign data_out  = dat_q;

endmodule

// File: tb/tb_mux_lane_scheduler.sv
// Directed bench for mux_lane_scheduler with BURST_LEN=2; honours STRICT_PRIO_EN for lane-0 priority expectations.
module tb_mux_lane_scheduler;

    logic       clk_4f = 1'b0;
    logic       reset;
    logic [3:0] valid_in;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic [3:0] ready_out;
    logic [1:0] selector;
    logic       valid_out;
    logic [7:0] data_out;
    logic       ready_in;

    int checks = 0;
    int errors = 0;

    always #5 clk_4f = ~clk_4f;

    mux_lane_scheduler #(.DATA_W(8), .BURST_LEN(2)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in0  (data_in0),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .data_in3  (data_in3),
        .ready_out (ready_out),
        .selector  (selector),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in)
    );

    // Wait for the falling edge, then compare all observable outputs.
    task automatic nchk(input string tag, input logic vo, input logic [7:0] d,
                        input logic [1:0] sel, input logic [3:0] ro);
        @(negedge clk_4f);
        checks++;
        assert (valid_out === vo) else begin
            errors++;
            $error("FAIL %s valid_out: got %b expected %b", tag, valid_out, vo);
        end
        checks++;
        assert (data_out === d) else begin
            errors++;
            $error("FAIL %s data_out: got %h expected %h", tag, data_out, d);
        end
        checks++;
        assert (selector === sel) else begin
            errors++;
            $error("FAIL %s selector: got %0d expected %0d", tag, selector, sel);
        end
        checks++;
        assert (ready_out === ro) else begin
            errors++;
            $error("FAIL %s ready_out: got %b expected %b", tag, ready_out, ro);
        end
    endtask

    logic [1:0] g_a, g_b;
    logic [3:0] r_a, r_b;
    logic [7:0] d_a, d_b;

    initial begin
        reset    = 1'b1;
        valid_in = 4'hF;
        data_in0 = 8'hEE;
        data_in1 = 8'h01;
        data_in2 = 8'hFF;
        data_in3 = 8'hFD;
        ready_in = 1'b1;

        // Held in reset with every lane requesting.
        for (int i = 0; i < 5; i++) nchk("reset_hold", 1'b0, 8'h00, 2'd0, 4'b0000);
        reset = 1'b0;

        // Round-robin bursts of two, one bubble between bursts.
        nchk("rr_e1",  1'b0, 8'h00, 2'd0, 4'b0001);
        nchk("rr_e2",  1'b1, 8'hEE, 2'd0, 4'b0001);
        nchk("rr_e3",  1'b1, 8'hEE, 2'd0, 4'b0000);
        nchk("rr_e4",  1'b0, 8'hEE, 2'd1, 4'b0010);
        nchk("rr_e5",  1'b1, 8'h01, 2'd1, 4'b0010);
        nchk("rr_e6",  1'b1, 8'h01, 2'd1, 4'b0000);
        nchk("rr_e7",  1'b0, 8'h01, 2'd2, 4'b0100);
        nchk("rr_e8",  1'b1, 8'hFF, 2'd2, 4'b0100);
        nchk("rr_e9",  1'b1, 8'hFF, 2'd2, 4'b0000);
        nchk("rr_e10", 1'b0, 8'hFF, 2'd3, 4'b1000);
        nchk("rr_e11", 1'b1, 8'hFD, 2'd3, 4'b1000);
        nchk("rr_e12", 1'b1, 8'hFD, 2'd3, 4'b0000);
        nchk("rr_e13", 1'b0, 8'hFD, 2'd0, 4'b0001);
        nchk("rr_e14", 1'b1, 8'hEE, 2'd0, 4'b0001);
        nchk("rr_e15", 1'b1, 8'hEE, 2'd0, 4'b0000);
        nchk("rr_e16", 1'b0, 8'hEE, 2'd1, 4'b0010);

        // Backpressure in the middle of the lane-1 burst; second beat carries new data.
        nchk("bp_first", 1'b1, 8'h01, 2'd1, 4'b0010);
        data_in1 = 8'h55;
        ready_in = 1'b0;
        nchk("bp_stall1", 1'b1, 8'h01, 2'd1, 4'b0000);
        nchk("bp_stall2", 1'b1, 8'h01, 2'd1, 4'b0000);
        nchk("bp_stall3", 1'b1, 8'h01, 2'd1, 4'b0000);
        ready_in = 1'b1;
        nchk("bp_resume", 1'b1, 8'h55, 2'd1, 4'b0000);
        nchk("bp_next",   1'b0, 8'h55, 2'd2, 4'b0100);
        nchk("bp_lane2",  1'b1, 8'hFF, 2'd2, 4'b0100);

        // Lane 2 alone: one beat, then valid drops and the burst ends early.
        valid_in = 4'b0100;
        nchk("solo_end",   1'b1, 8'hFF, 2'd2, 4'b0000);
        nchk("solo_grant", 1'b0, 8'hFF, 2'd2, 4'b0100);
        data_in2 = 8'h77;
        nchk("solo_beat",  1'b1, 8'h77, 2'd2, 4'b0100);
        valid_in = 4'b0000;
        nchk("early_end",  1'b0, 8'h77, 2'd2, 4'b0000);
        nchk("idle_hold",  1'b0, 8'h77, 2'd2, 4'b0000);
        valid_in = 4'b0100;
        nchk("regrant2",   1'b0, 8'h77, 2'd2, 4'b0100);
        nchk("regrant2_b", 1'b1, 8'h77, 2'd2, 4'b0100);

        // Lane 1 burst interrupted by reset.
        valid_in = 4'b0010;
        data_in1 = 8'h31;
        nchk("l1_early",  1'b0, 8'h77, 2'd2, 4'b0000);
        nchk("l1_grant",  1'b0, 8'h77, 2'd1, 4'b0010);
        nchk("l1_beat",   1'b1, 8'h31, 2'd1, 4'b0010);
        reset = 1'b1;
        nchk("mid_reset", 1'b0, 8'h00, 2'd0, 4'b0000);
        reset    = 1'b0;
        valid_in = 4'hF;
        nchk("post_rst_grant", 1'b0, 8'h00, 2'd0, 4'b0001);
        nchk("post_rst_beat",  1'b1, 8'hEE, 2'd0, 4'b0001);

        // Lanes 0 and 3 requesting continuously.
        valid_in = 4'b1001;
        nchk("pair_end0", 1'b1, 8'hEE, 2'd0, 4'b0000);
`ifdef STRICT_PRIO_EN
        g_a = 2'd0; r_a = 4'b0001; d_a = 8'hEE;
        g_b = 2'd0; r_b = 4'b0001; d_b = 8'hEE;
`else
        g_a = 2'd3; r_a = 4'b1000; d_a = 8'hFD;
        g_b = 2'd0; r_b = 4'b0001; d_b = 8'hEE;
`endif
        for (int k = 0; k < 2; k++) begin
            nchk("pair_grant_a", 1'b0, 8'hEE, g_a, r_a);
            nchk("pair_beat_a",  1'b1, d_a,   g_a, r_a);
            nchk("pair_end_a",   1'b1, d_a,   g_a, 4'b0000);
            nchk("pair_grant_b", 1'b0, d_a,   g_b, r_b);
            nchk("pair_beat_b",  1'b1, d_b,   g_b, r_b);
            nchk("pair_end_b",   1'b1, d_b,   g_b, 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
